// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between message sources, the UART_Tx sharing arbiter and the UART_Tx itself.
// The master side is the sources and the UART_Tx; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_byte;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   grant;
    logic                 transmit_ready;
    logic                 tx_ctrl;
    logic [7:0]           tx_byte;
    logic                 busy;

    modport master (
        output req, req_byte, req_last, transmit_ready,
        input  req_ack, grant, tx_ctrl, tx_byte, busy
    );

    modport slave (
        input  req, req_byte, req_last, transmit_ready,
        output req_ack, grant, tx_ctrl, tx_byte, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART_Tx between NUM_REQ message sources.
// A granted source keeps the transmitter until the last byte of its message is sent.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned GAP_CYCLES    = 0,
    parameter int unsigned START_TIMEOUT = 16
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned IdxW   = $clog2(NUM_REQ);
    localparam int unsigned CntMax = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] StartLast = CntW'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);
    localparam logic [CntW-1:0] GapLast   = CntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StKick,
        StWaitStart,
        StWaitDone,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic              last_q, last_d;
    logic [7:0]        byte_q, byte_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              pick_valid;
    logic [IdxW-1:0]   pick_idx;
    logic              end_of_byte;

    function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return IdxW'(sum);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            last_q  <= 1'b0;
            byte_q  <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            last_q  <= last_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        last_d      = last_q;
        byte_d      = byte_q;
        cnt_d       = cnt_q;
        end_of_byte = 1'b0;
        pick_valid  = 1'b0;
        pick_idx    = '0;

        // First requester at or above the rr pointer, wrapping.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!pick_valid && bus.req[wrap_add(rr_q, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_add(rr_q, k);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (pick_valid && bus.transmit_ready) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    state_d           = StLoad;
                end
            end
            StLoad: begin
                byte_d  = bus.req_byte[{owner_q, 3'b000} +: 8];
                last_d  = bus.req_last[owner_q];
                state_d = StKick;
            end
            StKick: begin
                cnt_d   = '0;
                state_d = StWaitStart;
            end
            StWaitStart: begin
                // A UART that never reports busy must not stall the arbiter.
                if (!bus.transmit_ready || (cnt_q == StartLast)) begin
                    state_d = StWaitDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (bus.transmit_ready) begin
                    if (GAP_CYCLES > 0) begin
                        cnt_d   = '0;
                        state_d = StGap;
                    end else begin
                        end_of_byte = 1'b1;
                    end
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    end_of_byte = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A source dropping req mid-message aborts it and is released like a completed one.
        if (end_of_byte) begin
            if (!last_q && bus.req[owner_q]) begin
                state_d = StLoad;
            end else begin
                state_d = StIdle;
                grant_d = '0;
                rr_d    = wrap_add(owner_q, 1);
            end
        end
    end

    always_comb begin
        bus.req_ack = '0;
        if (state_q == StLoad) bus.req_ack = grant_q;
        bus.tx_ctrl = (state_q == StKick);
        bus.busy    = (state_q != StIdle);
        bus.grant   = grant_q;
        bus.tx_byte = byte_q;
    end
endmodule
